// File: rtl/jtopl_wrsched.sv
// Round-robin write scheduler for the OPL register port. Each accepted request becomes
// an address strobe and a data strobe. Each strobe is followed by a hold-off counted in cen ticks.
//
// state | meaning
// IDLE  | no write in flight; arbitrating between requesters every clk
// ADDR  | address strobe on the port (opl_addr=0, opl_din=register index)
// AWAIT | counting down the post-address hold-off on cen
// DATA  | data strobe on the port (opl_addr=1, opl_din=data byte)
// DWAIT | counting down the post-data hold-off on cen
module jtopl_wrsched #(
   parameter int ADDR_WAIT = 12,
   parameter int DATA_WAIT = 84,
   parameter int SKIP_ADDR = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       req0_valid,
   input  logic [7:0] req0_reg,
   input  logic [7:0] req0_dat,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_reg,
   input  logic [7:0] req1_dat,
   output logic       req1_ready,
   output logic [7:0] opl_din,
   output logic       opl_addr,
   output logic       opl_write,
   output logic       busy
);

   localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int CW   = (MAXW > 0) ? $clog2(MAXW + 1) : 1;
   localparam logic [CW-1:0] AW  = CW'(ADDR_WAIT);
   localparam logic [CW-1:0] DW  = CW'(DATA_WAIT);
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      AWAIT = 3'd2,
      DATA  = 3'd3,
      DWAIT = 3'd4
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last_grant;
   logic          last_reg_v;
   logic [7:0]    last_reg;
   logic [7:0]    lat_reg;
   logic [7:0]    lat_dat;

   logic          idle;
   logic          grant0;
   logic          grant1;
   logic [7:0]    sel_reg;
   logic [7:0]    sel_dat;
   logic          skip;
   logic          wait_done;

   // A wait state ends on the clk whose cen tick brings the count to zero.
   always_comb begin
      idle      = (state == IDLE) && !rst;
      grant0    = idle && req0_valid && (!req1_valid || last_grant);
      grant1    = idle && req1_valid && (!req0_valid || !last_grant);
      sel_reg   = grant1 ? req1_reg : req0_reg;
      sel_dat   = grant1 ? req1_dat : req0_dat;
      skip      = (SKIP_ADDR != 0) && last_reg_v && (sel_reg == last_reg);
      wait_done = (cnt == '0) || (cen && (cnt == ONE));
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         last_reg_v <= 1'b0;
         last_reg   <= '0;
         lat_reg    <= '0;
         lat_dat    <= '0;
         opl_din    <= '0;
         opl_addr   <= 1'b0;
         opl_write  <= 1'b0;
      end else begin
         opl_write <= 1'b0;
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  last_grant <= grant1;
                  lat_reg    <= sel_reg;
                  lat_dat    <= sel_dat;
                  opl_write  <= 1'b1;
                  if (skip) begin
                     state    <= DATA;
                     opl_addr <= 1'b1;
                     opl_din  <= sel_dat;
                  end else begin
                     state    <= ADDR;
                     opl_addr <= 1'b0;
                     opl_din  <= sel_reg;
                  end
               end
            end
            ADDR: begin
               last_reg   <= lat_reg;
               last_reg_v <= 1'b1;
               cnt        <= AW;
               state      <= AWAIT;
            end
            AWAIT: begin
               if (cen && (cnt != '0))
                  cnt <= cnt - ONE;
               if (wait_done) begin
                  state     <= DATA;
                  opl_write <= 1'b1;
                  opl_addr  <= 1'b1;
                  opl_din   <= lat_dat;
               end
            end
            DATA: begin
               cnt   <= DW;
               state <= DWAIT;
            end
            DWAIT: begin
               if (cen && (cnt != '0))
                  cnt <= cnt - ONE;
               if (wait_done)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtopl_wrsched.sv
// Testbench for jtopl_wrsched: a script-based reference model checked every clk,
// plus directed scenarios with hand-computed strobe timing.
module tb_jtopl_wrsched;

   localparam int AW = 12;
   localparam int DW = 84;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b1;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_reg = 8'h00;
   logic [7:0] req0_dat = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_reg = 8'h00;
   logic [7:0] req1_dat = 8'h00;
   logic       req1_ready;
   logic [7:0] opl_din;
   logic       opl_addr;
   logic       opl_write;
   logic       busy;

   always #5 clk = ~clk;

   jtopl_wrsched #(.ADDR_WAIT(AW), .DATA_WAIT(DW), .SKIP_ADDR(1)) dut (
      .clk(clk), .rst(rst), .cen(cen),
      .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_dat(req0_dat), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_dat(req1_dat), .req1_ready(req1_ready),
      .opl_din(opl_din), .opl_addr(opl_addr), .opl_write(opl_write), .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int cen_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected port activity as a script: strobe items and wait-for-N-cen-ticks items.
   typedef struct {
      bit         is_wait;
      bit         a;
      logic [7:0] d;
      int         n;
   } item_t;

   function automatic item_t mk(input bit w, input bit a, input logic [7:0] d, input int n);
      item_t t;
      t.is_wait = w;
      t.a       = a;
      t.d       = d;
      t.n       = n;
      return t;
   endfunction

   int         s_cyc[$];
   int         s_addr[$];
   int         s_din[$];
   int         s_cpre[$];
   int         s_cself[$];
   int         f_cyc[$];
   int         f_cpre[$];
   int         g_who[$];
   int         cen_cum = 0;
   bit         prev_busy = 1'b0;

   function automatic int sc(input int i);
      return (i < s_cyc.size()) ? s_cyc[i] : -1;
   endfunction
   function automatic int sa(input int i);
      return (i < s_addr.size()) ? s_addr[i] : -1;
   endfunction
   function automatic int sd(input int i);
      return (i < s_din.size()) ? s_din[i] : -1;
   endfunction
   function automatic int gw(input int i);
      return (i < g_who.size()) ? g_who[i] : -1;
   endfunction
   function automatic int last_fall();
      return (f_cyc.size() > 0) ? f_cyc[f_cyc.size() - 1] : -1;
   endfunction
   function automatic int ticks_between(input int i, input int j);
      if (j >= s_cyc.size()) return -1;
      return s_cpre[j] - s_cpre[i] - s_cself[i];
   endfunction
   function automatic int ticks_to_fall(input int i);
      if (i >= s_cyc.size() || f_cyc.size() == 0) return -1;
      return f_cpre[f_cyc.size() - 1] - s_cpre[i] - s_cself[i];
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (cen_mode)
         1:       cen = (cyc % 4 == 0);
         2:       cen = 1'b0;
         default: cen = 1'b1;
      endcase
   end

   initial begin : model
      item_t      scr[$];
      item_t      h;
      bit         m_lg, m_lrv, m_live, m_addr;
      logic [7:0] m_lr, m_din, rg, dt;
      bit         e_r0, e_r1, e_w, e_b, g0, g1;
      m_lg = 1'b1; m_lrv = 1'b0; m_live = 1'b0; m_addr = 1'b0;
      m_lr = 8'h00; m_din = 8'h00;
      forever begin
         @(negedge clk);
         if (m_live) begin
            e_r0 = 1'b0; e_r1 = 1'b0; e_w = 1'b0;
            e_b  = (scr.size() != 0);
            if (scr.size() == 0) begin
               if (!rst) begin
                  g0 = req0_valid && (!req1_valid || m_lg);
                  g1 = req1_valid && (!req0_valid || !m_lg);
                  e_r0 = g0;
                  e_r1 = g1;
                  if (g0 || g1) begin
                     rg   = g1 ? req1_reg : req0_reg;
                     dt   = g1 ? req1_dat : req0_dat;
                     m_lg = g1;
                     if (!(m_lrv && rg == m_lr)) begin
                        scr.push_back(mk(1'b0, 1'b0, rg, 0));
                        scr.push_back(mk(1'b1, 1'b0, 8'h00, AW));
                        m_lr  = rg;
                        m_lrv = 1'b1;
                     end
                     scr.push_back(mk(1'b0, 1'b1, dt, 0));
                     scr.push_back(mk(1'b1, 1'b0, 8'h00, DW));
                  end
               end
            end else begin
               h = scr[0];
               if (!h.is_wait) begin
                  e_w    = 1'b1;
                  m_addr = h.a;
                  m_din  = h.d;
                  void'(scr.pop_front());
               end else if (h.n == 0) begin
                  void'(scr.pop_front());
               end else if (cen) begin
                  h.n = h.n - 1;
                  if (h.n == 0) void'(scr.pop_front());
                  else scr[0] = h;
               end
            end
            check("m_ready0", req0_ready, e_r0);
            check("m_ready1", req1_ready, e_r1);
            check("m_write", opl_write, e_w);
            check("m_busy", busy, e_b);
            check("m_addr", opl_addr, m_addr);
            check("m_din", opl_din, m_din);
         end
         if (opl_write === 1'b1) begin
            s_cyc.push_back(cyc);
            s_addr.push_back(int'(opl_addr));
            s_din.push_back(int'(opl_din));
            s_cpre.push_back(cen_cum);
            s_cself.push_back((cen === 1'b1) ? 1 : 0);
         end
         if (req0_ready === 1'b1) g_who.push_back(0);
         if (req1_ready === 1'b1) g_who.push_back(1);
         if (prev_busy && busy === 1'b0) begin
            f_cyc.push_back(cyc);
            f_cpre.push_back(cen_cum);
         end
         prev_busy = (busy === 1'b1);
         if (cen === 1'b1) cen_cum++;
         if (rst) begin
            scr.delete();
            m_lg = 1'b1; m_lrv = 1'b0; m_lr = 8'h00;
            m_din = 8'h00; m_addr = 1'b0; m_live = 1'b1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy !== 1'b0 && k < budget);
      check("idle_within_budget", busy, 0);
      step();
   endtask

   task automatic do_write(input int who, input logic [7:0] rg, input logic [7:0] dt, output int acc);
      int k = 0;
      bit got = 1'b0;
      if (who == 0) begin
         req0_valid = 1'b1; req0_reg = rg; req0_dat = dt;
      end else begin
         req1_valid = 1'b1; req1_reg = rg; req1_dat = dt;
      end
      while (!got && k < 3000) begin
         @(negedge clk);
         k++;
         got = (who == 0) ? (req0_ready === 1'b1) : (req1_ready === 1'b1);
      end
      check("accept_within_budget", got, 1);
      acc = cyc;
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin : main
      int acc, acc2, base, gb, ng, k, nb;
      int exp_a[8];
      int exp_d[8];
      exp_a = '{0, 1, 0, 1, 0, 1, 0, 1};
      exp_d = '{8'h20, 8'h01, 8'h40, 8'h3F, 8'h20, 8'h01, 8'h40, 8'h3F};

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_write", opl_write, 0);
      check("reset_din", opl_din, 0);
      rst = 1'b0;

      // Single write, requester 0
      base = s_cyc.size(); gb = g_who.size();
      do_write(0, 8'hA0, 8'h44, acc);
      wait_idle(3000);
      check("t1_strobes", s_cyc.size() - base, 2);
      check("t1_addr_cycle", sc(base), acc + 1);
      check("t1_addr_phase", sa(base), 0);
      check("t1_addr_din", sd(base), 8'hA0);
      check("t1_data_gap", sc(base + 1) - sc(base), 13);
      check("t1_data_phase", sa(base + 1), 1);
      check("t1_data_din", sd(base + 1), 8'h44);
      check("t1_busy_drop", last_fall() - sc(base + 1), 85);
      check("t1_ready_pulses", g_who.size() - gb, 1);

      // Both requesters valid continuously
      pulse_rst();
      base = s_cyc.size(); gb = g_who.size();
      req0_valid = 1'b1; req0_reg = 8'h20; req0_dat = 8'h01;
      req1_valid = 1'b1; req1_reg = 8'h40; req1_dat = 8'h3F;
      ng = 0; k = 0;
      while (ng < 4 && k < 3000) begin
         @(negedge clk);
         k++;
         if (req0_ready === 1'b1 || req1_ready === 1'b1) ng++;
      end
      check("t2_four_grants", ng, 4);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle(3000);
      for (int i = 0; i < 4; i++) check("t2_grant_order", gw(gb + i), i % 2);
      check("t2_strobes", s_cyc.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         check("t2_phase", sa(base + i), exp_a[i]);
         check("t2_din", sd(base + i), exp_d[i]);
      end
      for (int i = 0; i < 7; i++)
         check("t2_gap", sc(base + i + 1) - sc(base + i), (i % 2 == 0) ? 13 : 86);

      // Requester 1 alone after requester 0 was last served
      do_write(0, 8'h60, 8'h11, acc);
      wait_idle(3000);
      base = s_cyc.size();
      req1_valid = 1'b1; req1_reg = 8'h61; req1_dat = 8'h12;
      @(negedge clk);
      check("t6_r1_immediate", req1_ready, 1);
      check("t6_r0_quiet", req0_ready, 0);
      acc = cyc;
      step();
      req1_valid = 1'b0;
      wait_idle(3000);
      check("t6_addr_cycle", sc(base), acc + 1);
      check("t6_addr_din", sd(base), 8'h61);
      check("t6_data_din", sd(base + 1), 8'h12);

      // Address-phase skipping on repeated register index
      pulse_rst();
      base = s_cyc.size();
      do_write(0, 8'hB0, 8'h20, acc);
      wait_idle(3000);
      do_write(0, 8'hB0, 8'h00, acc2);
      wait_idle(3000);
      do_write(1, 8'hB1, 8'h55, acc);
      wait_idle(3000);
      check("t3_strobes", s_cyc.size() - base, 5);
      check("t3_first_addr", sd(base) | (sa(base) << 8), 8'hB0);
      check("t3_skip_cycle", sc(base + 2), acc2 + 1);
      check("t3_skip_phase", sa(base + 2), 1);
      check("t3_skip_din", sd(base + 2), 8'h00);
      check("t3_next_addr", sd(base + 3) | (sa(base + 3) << 8), 8'hB1);
      check("t3_next_data", sd(base + 4) | (sa(base + 4) << 8), 16'h155);

      // cen 1-in-4, with a freeze in the address hold-off
      @(negedge clk);
      cen_mode = 1;
      step();
      base = s_cyc.size();
      do_write(0, 8'h30, 8'h0A, acc);
      repeat (10) step();
      @(negedge clk);
      cen_mode = 2;
      nb = s_cyc.size();
      repeat (200) @(negedge clk);
      check("t4_frozen_no_strobe", s_cyc.size(), nb);
      check("t4_frozen_busy", busy, 1);
      cen_mode = 1;
      step();
      wait_idle(3000);
      check("t4_strobes", s_cyc.size() - base, 2);
      check("t4_addr_ticks", ticks_between(base, base + 1), 12);
      check("t4_data_din", sd(base + 1), 8'h0A);
      check("t4_data_ticks", ticks_to_fall(base + 1), 84);

      // Reset during the data hold-off
      @(negedge clk);
      cen_mode = 0;
      step();
      base = s_cyc.size();
      do_write(0, 8'h70, 8'h77, acc);
      k = 0;
      while (s_cyc.size() < base + 2 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("t5_reached_dwait", s_cyc.size() - base, 2);
      step();
      repeat (5) step();
      pulse_rst();
      @(negedge clk);
      check("t5_busy_after_rst", busy, 0);
      check("t5_write_after_rst", opl_write, 0);
      check("t5_din_after_rst", opl_din, 0);
      check("t5_addr_after_rst", opl_addr, 0);
      step();
      base = s_cyc.size();
      do_write(0, 8'h70, 8'h78, acc);
      wait_idle(3000);
      check("t5_strobes", s_cyc.size() - base, 2);
      check("t5_addr_phase", sa(base), 0);
      check("t5_addr_din", sd(base), 8'h70);
      check("t5_data_din", sd(base + 1), 8'h78);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
